// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the data-memory arbiter: request payload going in,
// grant and load response coming back.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, f3, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, f3, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port byte-addressed data memory:
// port 0 has priority, port 1 is guaranteed a grant after STARVE_LIMIT denials.
module dmem_arbiter #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           Clock,
    input  logic           nReset,
    dmem_arbiter_if.slave  p0,
    dmem_arbiter_if.slave  p1,
    output logic [2:0]     mem_f3,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_data,
    output logic           mem_wmem,
    output logic           mem_rmem,
    input  logic [31:0]    mem_out
);
    localparam int unsigned      CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [32:0]      ADDR_MAX = 33'(DEPTH) - 33'd1;

    function automatic logic [2:0] size_m1(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            default: return 3'd3;
        endcase
    endfunction

    // The last byte is computed in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic        bad_code;
        logic [32:0] last_byte;
        bad_code  = we ? (f3 > 3'b010) : ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        last_byte = {1'b0, addr} + {30'd0, size_m1(f3[1:0])};
        return bad_code || (last_byte > ADDR_MAX);
    endfunction

    logic             gnt0_s;
    logic             gnt1_s;
    logic             any_gnt_s;
    logic             sel_we_s;
    logic [2:0]       sel_f3_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic             fault_s;
    logic [CNT_W-1:0] starve_cnt_r;
    logic             pend_vld_r;
    logic             pend_port_r;
    logic             pend_err_r;

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!nReset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p1.req && (!p0.req || (starve_cnt_r == CNT_MAX))) begin
            gnt1_s = 1'b1;
        end else if (p0.req) begin
            gnt0_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Payload mux of the granted port and fault classification.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_f3_s    = 3'b000;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (gnt1_s) begin
            sel_we_s    = p1.we;
            sel_f3_s    = p1.f3;
            sel_addr_s  = p1.addr;
            sel_wdata_s = p1.wdata;
        end else if (gnt0_s) begin
            sel_we_s    = p0.we;
            sel_f3_s    = p0.f3;
            sel_addr_s  = p0.addr;
            sel_wdata_s = p0.wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_f3_s    = 3'b000;
            sel_addr_s  = 32'd0;
            sel_wdata_s = 32'd0;
        end
        any_gnt_s = gnt0_s | gnt1_s;
        fault_s   = any_gnt_s & is_fault(sel_we_s, sel_f3_s, sel_addr_s);
    end

    // Memory drive: strobes only for granted, non-faulting accesses.
    always_comb begin
        mem_f3   = sel_f3_s;
        mem_addr = sel_addr_s;
        mem_data = sel_wdata_s;
        mem_wmem = any_gnt_s & sel_we_s & ~fault_s;
        mem_rmem = any_gnt_s & ~sel_we_s & ~fault_s;
    end

    // Starvation counter: consecutive cycles port 1 was requesting but denied.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            starve_cnt_r <= '0;
        end else if (!p1.req || gnt1_s) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != CNT_MAX) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Response stage: loads and faulting accesses answer one cycle after acceptance.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pend_vld_r  <= 1'b0;
            pend_port_r <= 1'b0;
            pend_err_r  <= 1'b0;
        end else begin
            pend_vld_r  <= any_gnt_s & (~sel_we_s | fault_s);
            pend_port_r <= gnt1_s;
            pend_err_r  <= fault_s;
        end
    end

    assign p0.gnt    = gnt0_s;
    assign p1.gnt    = gnt1_s;
    assign p0.rvalid = pend_vld_r & ~pend_port_r;
    assign p1.rvalid = pend_vld_r & pend_port_r;
    assign p0.err    = pend_vld_r & ~pend_port_r & pend_err_r;
    assign p1.err    = pend_vld_r & pend_port_r & pend_err_r;
    assign p0.rdata  = (pend_vld_r && !pend_port_r && !pend_err_r) ? mem_out : 32'd0;
    assign p1.rdata  = (pend_vld_r && pend_port_r && !pend_err_r) ? mem_out : 32'd0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// byte-array reference model of the arbitration, fault and response rules.
module tb_dmem_arbiter;
    localparam int DEPTH        = 1024;
    localparam int STARVE_LIMIT = 4;

    logic        Clock;
    logic        nReset;
    logic [2:0]  mem_f3;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wmem;
    logic        mem_rmem;
    logic [31:0] mem_out;
    int          checks;
    int          errors;

    logic [7:0] dev_mem [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .Clock(Clock), .nReset(nReset), .p0(p0_if), .p1(p1_if),
        .mem_f3(mem_f3), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_out(mem_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Big-endian memory device with registered read data.
    function automatic logic [31:0] dev_read(input logic [31:0] a, input logic [2:0] f3);
        logic [9:0] i;
        i = a[9:0];
        case (f3)
            3'b000:  return {{24{dev_mem[i][7]}}, dev_mem[i]};
            3'b100:  return {24'd0, dev_mem[i]};
            3'b001:  return {{16{dev_mem[i][7]}}, dev_mem[i], dev_mem[i+10'd1]};
            3'b101:  return {16'd0, dev_mem[i], dev_mem[i+10'd1]};
            default: return {dev_mem[i], dev_mem[i+10'd1], dev_mem[i+10'd2], dev_mem[i+10'd3]};
        endcase
    endfunction

    always @(posedge Clock) begin
        if (mem_rmem) mem_out <= dev_read(mem_addr, mem_f3);
        if (mem_wmem) begin
            case (mem_f3[1:0])
                2'b00: dev_mem[mem_addr[9:0]] <= mem_data[7:0];
                2'b01: begin
                    dev_mem[mem_addr[9:0]]       <= mem_data[15:8];
                    dev_mem[mem_addr[9:0]+10'd1] <= mem_data[7:0];
                end
                default: begin
                    dev_mem[mem_addr[9:0]]       <= mem_data[31:24];
                    dev_mem[mem_addr[9:0]+10'd1] <= mem_data[23:16];
                    dev_mem[mem_addr[9:0]+10'd2] <= mem_data[15:8];
                    dev_mem[mem_addr[9:0]+10'd3] <= mem_data[7:0];
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic bit ref_fault(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        longint a;
        int     size;
        a    = {32'd0, addr};
        size = 1 << f3[1:0];
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (a + size - 1) > (DEPTH - 1);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int     size;
        longint val;
        size = 1 << f3[1:0];
        val  = 0;
        for (int i = 0; i < size; i++) val = val * 256 + ref_mem[int'(addr) + i];
        if (!f3[2] && size < 4 && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
        return val[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wdata);
        int size;
        size = 1 << f3[1:0];
        for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = 8'((wdata >> (8 * (size - 1 - i))) & 32'hFF);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int n, input bit req, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (n == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.f3 = f3; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.f3 = f3; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        nReset = 1'b0;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        checks++; if (p0_if.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", p0_if.gnt); end
        checks++; if (mem_rmem !== 1'b0 || mem_addr !== 32'd0 || mem_f3 !== 3'd0) begin errors++; $display("FAIL reset_mem: got rmem=%b addr=%h f3=%0d want 0", mem_rmem, mem_addr, mem_f3); end
        checks++; if (p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0 || p0_if.rdata !== 32'd0 || p0_if.err !== 1'b0) begin errors++; $display("FAIL reset_resp: got rv0=%b rv1=%b rd0=%h err0=%b want 0", p0_if.rvalid, p1_if.rvalid, p0_if.rdata, p0_if.err); end
        next_cycle();
        idle();
        nReset = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_basic();
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        @(negedge Clock);
        checks++; if (p0_if.gnt !== 1'b1 || p1_if.gnt !== 1'b0) begin errors++; $display("FAIL load_gnt: got p0=%b p1=%b want 1/0", p0_if.gnt, p1_if.gnt); end
        checks++; if (mem_rmem !== 1'b1 || mem_wmem !== 1'b0 || mem_addr !== 32'h10) begin errors++; $display("FAIL load_mem: got rmem=%b wmem=%b addr=%h want 1/0/10", mem_rmem, mem_wmem, mem_addr); end
        next_cycle();
        idle();
        @(negedge Clock);
        checks++; if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 32'h11223344 || p0_if.err !== 1'b0) begin errors++; $display("FAIL load_resp: got rv=%b rd=%h err=%b want 1/11223344/0", p0_if.rvalid, p0_if.rdata, p0_if.err); end
        checks++; if (p1_if.rvalid !== 1'b0) begin errors++; $display("FAIL load_xroute: got p1 rvalid=%b want 0", p1_if.rvalid); end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp1;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h44, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            exp1 = (i == 4 || i == 9);
            checks++;
            if (p1_if.gnt !== exp1 || p0_if.gnt !== !exp1) begin
                errors++; $display("FAIL starve_gnt[%0d]: got p0=%b p1=%b want p1=%b", i, p0_if.gnt, p1_if.gnt, exp1);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_store_fault();
        drive(1, 1'b1, 1'b1, 3'b001, 32'h3FF, 32'h0000ABCD);
        @(negedge Clock);
        checks++; if (p1_if.gnt !== 1'b1 || mem_wmem !== 1'b0 || mem_rmem !== 1'b0) begin errors++; $display("FAIL sfault_gnt: got gnt=%b wmem=%b rmem=%b want 1/0/0", p1_if.gnt, mem_wmem, mem_rmem); end
        next_cycle();
        idle();
        @(negedge Clock);
        checks++; if (p1_if.rvalid !== 1'b1 || p1_if.err !== 1'b1 || p1_if.rdata !== 32'd0) begin errors++; $display("FAIL sfault_resp: got rv=%b err=%b rd=%h want 1/1/0", p1_if.rvalid, p1_if.err, p1_if.rdata); end
        checks++; if (dev_mem[10'h3FF] !== ref_mem[10'h3FF]) begin errors++; $display("FAIL sfault_mem: got %h want %h", dev_mem[10'h3FF], ref_mem[10'h3FF]); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        @(negedge Clock);
        checks++; if (p0_if.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b want 1", p0_if.gnt); end
        next_cycle();
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h24, 32'd0);
        @(negedge Clock);
        checks++; if (p1_if.gnt !== 1'b1 || p0_if.gnt !== 1'b0) begin errors++; $display("FAIL b2b_gnt1: got p0=%b p1=%b want 0/1", p0_if.gnt, p1_if.gnt); end
        checks++; if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== ref_load(32'h20, 3'b010) || p1_if.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_resp0: got rv0=%b rd0=%h rv1=%b want 1/%h/0", p0_if.rvalid, p0_if.rdata, p1_if.rvalid, ref_load(32'h20, 3'b010)); end
        next_cycle();
        idle();
        @(negedge Clock);
        checks++; if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== ref_load(32'h24, 3'b010) || p0_if.rvalid !== 1'b0) begin errors++; $display("FAIL b2b_resp1: got rv1=%b rd1=%h rv0=%b want 1/%h/0", p1_if.rvalid, p1_if.rdata, p0_if.rvalid, ref_load(32'h24, 3'b010)); end
        next_cycle();
    endtask

    task automatic test_fault_edges();
        logic [2:0]  f3s   [4] = '{3'b110, 3'b010, 3'b010, 3'b101};
        logic [31:0] addrs [4] = '{32'h30, 32'h3FC, 32'h3FD, 32'h3FE};
        bit          efs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b0, f3s[i], addrs[i], 32'd0);
            @(negedge Clock);
            checks++; if (p0_if.gnt !== 1'b1 || mem_rmem !== !efs[i]) begin errors++; $display("FAIL edge_rmem[%0d]: got gnt=%b rmem=%b want 1/%b", i, p0_if.gnt, mem_rmem, !efs[i]); end
            next_cycle();
            idle();
            @(negedge Clock);
            checks++;
            if (p0_if.rvalid !== 1'b1 || p0_if.err !== efs[i] || p0_if.rdata !== (efs[i] ? 32'd0 : ref_load(addrs[i], f3s[i]))) begin
                errors++; $display("FAIL edge_resp[%0d]: got rv=%b err=%b rd=%h want 1/%b", i, p0_if.rvalid, p0_if.err, p0_if.rdata, efs[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        bit exp1;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h14, 32'd0);
        for (int i = 0; i < 3; i++) next_cycle();
        idle();
        nReset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            checks++; if (p0_if.rvalid !== 1'b0 || p0_if.rdata !== 32'd0) begin errors++; $display("FAIL rstmid_hold[%0d]: got rv=%b rd=%h want 0/0", i, p0_if.rvalid, p0_if.rdata); end
            next_cycle();
        end
        nReset = 1'b1;
        drive(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h14, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            exp1 = (i == 4);
            checks++; if (p1_if.gnt !== exp1) begin errors++; $display("FAIL rstmid_starve[%0d]: got p1 gnt=%b want %b", i, p1_if.gnt, exp1); end
            if (i == 0) begin
                checks++; if (p0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_norv: got rv=%b want 0", p0_if.rvalid); end
            end
            next_cycle();
        end
        idle();
        next_cycle();
        drive(1, 1'b1, 1'b0, 3'b000, 32'h08, 32'd0);
        @(negedge Clock);
        checks++; if (p1_if.gnt !== 1'b1) begin errors++; $display("FAIL rstmid_p1gnt: got %b want 1", p1_if.gnt); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        bit          act [2] = '{1'b0, 1'b0};
        bit          rwe [2];
        logic [2:0]  rf3 [2];
        logic [31:0] raddr [2];
        logic [31:0] rwd [2];
        int          denied = 0;
        bit          pv = 1'b0, pe = 1'b0, g0, g1, f, gx;
        int          pp = 0, w;
        logic [31:0] pd = 32'd0, ea, ed;
        logic [2:0]  ef;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (!act[n] && $urandom_range(0, 2) != 0) begin
                    act[n] = 1'b1;
                    rwe[n] = 1'($urandom_range(0, 1));
                    rf3[n] = 3'($urandom_range(0, 7));
                    case ($urandom_range(0, 5))
                        0:       raddr[n] = 32'($urandom_range(DEPTH - 4, DEPTH + 4));
                        1:       raddr[n] = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                        default: raddr[n] = 32'($urandom_range(0, DEPTH - 1));
                    endcase
                    rwd[n] = $urandom();
                end
                if (act[n]) drive(n, 1'b1, rwe[n], rf3[n], raddr[n], rwd[n]);
                else        drive(n, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            end
            @(negedge Clock);
            g1 = act[1] && (!act[0] || denied >= STARVE_LIMIT);
            g0 = act[0] && !g1;
            gx = g0 || g1;
            w  = g1 ? 1 : 0;
            f  = gx && ref_fault(rwe[w], rf3[w], raddr[w]);
            ea = gx ? raddr[w] : 32'd0;
            ef = gx ? rf3[w] : 3'd0;
            ed = gx ? rwd[w] : 32'd0;
            checks++; if (p0_if.gnt !== g0 || p1_if.gnt !== g1) begin errors++; $display("FAIL rnd_gnt@%0d: got %b%b want %b%b", cyc, p0_if.gnt, p1_if.gnt, g0, g1); end
            checks++; if (mem_addr !== ea || mem_f3 !== ef || mem_data !== ed) begin errors++; $display("FAIL rnd_bus@%0d: got %h/%0d/%h want %h/%0d/%h", cyc, mem_addr, mem_f3, mem_data, ea, ef, ed); end
            checks++; if (mem_wmem !== (gx && rwe[w] && !f) || mem_rmem !== (gx && !rwe[w] && !f)) begin errors++; $display("FAIL rnd_strobe@%0d: got w=%b r=%b want w=%b r=%b", cyc, mem_wmem, mem_rmem, gx && rwe[w] && !f, gx && !rwe[w] && !f); end
            checks++;
            if (p0_if.rvalid !== (pv && pp == 0) || p0_if.err !== (pv && pp == 0 && pe) || p0_if.rdata !== ((pv && pp == 0) ? pd : 32'd0)) begin
                errors++; $display("FAIL rnd_resp0@%0d: got %b/%b/%h want %b/%b/%h", cyc, p0_if.rvalid, p0_if.err, p0_if.rdata, pv && pp == 0, pv && pp == 0 && pe, (pv && pp == 0) ? pd : 32'd0);
            end
            checks++;
            if (p1_if.rvalid !== (pv && pp == 1) || p1_if.err !== (pv && pp == 1 && pe) || p1_if.rdata !== ((pv && pp == 1) ? pd : 32'd0)) begin
                errors++; $display("FAIL rnd_resp1@%0d: got %b/%b/%h want %b/%b/%h", cyc, p1_if.rvalid, p1_if.err, p1_if.rdata, pv && pp == 1, pv && pp == 1 && pe, (pv && pp == 1) ? pd : 32'd0);
            end
            denied = (act[1] && !g1) ? denied + 1 : 0;
            pv = gx && (!rwe[w] || f);
            pp = w;
            pe = f;
            pd = (pv && !f) ? ref_load(raddr[w], rf3[w]) : 32'd0;
            if (gx && rwe[w] && !f) ref_store(raddr[w], rf3[w], rwd[w]);
            if (gx) act[w] = 1'b0;
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    initial begin
        logic [7:0] b;
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom());
            dev_mem[i] = b;
            ref_mem[i] = b;
        end
        dev_mem[16] = 8'h11; dev_mem[17] = 8'h22; dev_mem[18] = 8'h33; dev_mem[19] = 8'h44;
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
        idle();
        test_reset();
        test_load_basic();
        test_starvation();
        test_store_fault();
        test_back_to_back();
        test_fault_edges();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
